// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: a latched instruction walks RD -> EX -> (MEM) -> WB,
// sequencing register-file reads, one ALU operation, an optional memory access and the PC.
module alu_issue_ctrl #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [31:0]          instr_word,
  output logic                 instr_ready,
  output logic [3:0]           rf_raddr1,
  output logic [3:0]           rf_raddr2,
  input  logic [BIT_WIDTH-1:0] rf_rdata1,
  input  logic [BIT_WIDTH-1:0] rf_rdata2,
  output logic                 rf_we,
  output logic [3:0]           rf_waddr,
  output logic [BIT_WIDTH-1:0] rf_wdata,
  output logic [4:0]           alu_func,
  output logic [BIT_WIDTH-1:0] alu_a,
  output logic [BIT_WIDTH-1:0] alu_b,
  input  logic [BIT_WIDTH-1:0] alu_result,
  input  logic                 alu_comp_true,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [BIT_WIDTH-1:0] pc,
  output logic                 illegal
);

  localparam logic [3:0] OpAluR = 4'h0, OpAluI = 4'h8, OpCmpR = 4'h2, OpCmpI = 4'hA;
  localparam logic [3:0] OpBr   = 4'h6, OpLd   = 4'h7, OpSt   = 4'h5, OpJal  = 4'hB;

  typedef enum logic [2:0] {IDLE, RD, EX, MEM, WB} stateT;

  stateT                state;
  logic [31:0]          instr;
  logic [BIT_WIDTH-1:0] rs2Data, aluRes;
  logic                 compTrue;

  logic [3:0]           opc;
  logic [BIT_WIDTH-1:0] immExt, pcPlus4, exB;
  logic [4:0]           exFunc;
  logic                 isMemOp, writesRf;

  assign opc       = instr[3:0];
  assign immExt    = {{(BIT_WIDTH-16){instr[31]}}, instr[31:16]};
  assign pcPlus4   = pc + BIT_WIDTH'(4);
  assign rf_raddr1 = instr[15:12];
  assign rf_raddr2 = instr[19:16];
  assign instr_ready = (state == IDLE) && !reset;
  assign isMemOp   = (opc == OpLd) || (opc == OpSt);
  assign writesRf  = (opc == OpAluR) || (opc == OpAluI) || (opc == OpCmpR) ||
                     (opc == OpCmpI) || (opc == OpLd)   || (opc == OpJal);

  function automatic logic isLegal(input logic [3:0] op);
    return (op == OpAluR) || (op == OpAluI) || (op == OpCmpR) || (op == OpCmpI) ||
           (op == OpBr)   || (op == OpLd)   || (op == OpSt)   || (op == OpJal);
  endfunction

  // Operand/function selection is evaluated during RD and registered into EX.
  always_comb begin
    exFunc = 5'b00000;
    exB    = immExt;
    case (opc)
      OpAluR:         begin exFunc = {1'b0, instr[7:4]}; exB = rf_rdata2; end
      OpAluI:         exFunc = {1'b0, instr[7:4]};
      OpCmpR, OpBr:   begin exFunc = {1'b1, instr[7:4]}; exB = rf_rdata2; end
      OpCmpI:         exFunc = {1'b1, instr[7:4]};
      OpJal:          exB = immExt << 2;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      instr     <= '0;
      pc        <= '0;
      rs2Data   <= '0;
      aluRes    <= '0;
      compTrue  <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      alu_func  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          instr   <= instr_word;
          illegal <= !isLegal(instr_word[3:0]);
          state   <= RD;
        end
        RD: begin
          rs2Data <= rf_rdata2;
          if (illegal) begin
            illegal <= 1'b0;
            pc      <= pcPlus4;
            state   <= IDLE;
          end else begin
            alu_func <= exFunc;
            alu_a    <= rf_rdata1;
            alu_b    <= exB;
            state    <= EX;
          end
        end
        EX: begin
          aluRes   <= alu_result;
          compTrue <= alu_comp_true;
          alu_func <= '0;
          alu_a    <= '0;
          alu_b    <= '0;
          if (isMemOp) begin
            mem_req   <= 1'b1;
            mem_we    <= (opc == OpSt);
            mem_addr  <= alu_result;
            mem_wdata <= rs2Data;
            state     <= MEM;
          end else begin
            rf_we    <= writesRf;
            rf_waddr <= instr[11:8];
            rf_wdata <= (opc == OpJal) ? pcPlus4 : alu_result;
            state    <= WB;
          end
        end
        MEM: if (mem_ack) begin
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          rf_we    <= (opc == OpLd);
          rf_waddr <= instr[11:8];
          rf_wdata <= mem_rdata;
          state    <= WB;
        end
        WB: begin
          rf_we <= 1'b0;
          if (opc == OpJal)
            pc <= aluRes;
          else if (opc == OpBr && compTrue)
            pc <= pcPlus4 + (immExt << 2);
          else
            pc <= pcPlus4;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
